// File: rtl/wallace_mul_pipe.sv
// Purpose : pipelined WIDTH x WIDTH Wallace-tree multiplier; each operand is
//           signed or unsigned per beat; optional running accumulator.
// Latency : 3 cycles (operand reg -> carry-save reduction reg -> final add reg).
// Backpr. : one global enable adv = !out_valid || out_ready stalls every stage;
//           in_ready = adv (combinational from out_valid/out_ready only).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand beat handshake
//   a, b                 operands (WIDTH bits)
//   a_signed, b_signed   per-operand two's complement flags
//   acc_clr              restart the running sum with this beat   (ACC only)
//   out_valid/out_ready  result handshake
//   p                    2*WIDTH product (signed if either flag set)
//   acc                  ACC_W running sum of products            (ACC only)
// Optional accumulator: define WALLACE_MUL_ACC_EN.
module wallace_mul_pipe #(
  parameter int WIDTH = 8
`ifdef WALLACE_MUL_ACC_EN
  , parameter int ACC_W = 2*WIDTH+8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
`ifdef WALLACE_MUL_ACC_EN
  input  logic               acc_clr,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
`ifdef WALLACE_MUL_ACC_EN
  , output logic [ACC_W-1:0] acc
`endif
);

  // Number of 3:2 compression layers needed to bring r rows down to two.
  function automatic int csa_levels(input int rows_in);
    int r;
    int l;
    r = rows_in;
    l = 0;
    while (r > 2) begin
      r = (r / 3) * 2 + (r % 3);
      l = l + 1;
    end
    return l;
  endfunction

  localparam int N      = WIDTH + 1;     // extended operand width
  localparam int PW     = 2 * WIDTH;     // product width
  localparam int ROWS   = N + 1;         // N partial-product rows + constant row
  localparam int LEVELS = csa_levels(ROWS);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: extended operands ----------------
  logic         v1;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
`ifdef WALLACE_MUL_ACC_EN
  logic         sgn1;
  logic         clr1;
`endif

  // ---------------- S2: Wallace reduction ----------------
  // Both extended operands are treated as N-bit two's complement values, so a
  // single Baugh-Wooley array covers all four sign combinations: partial
  // products that involve exactly one operand MSB are inverted, and the
  // constant 2^N completes the correction (its other terms fall above PW).
  logic [PW-1:0] csa_cur [ROWS];
  logic [PW-1:0] csa_nxt [ROWS];
  logic [N-1:0]  pp_row;
  logic [PW-1:0] sum_row;
  logic [PW-1:0] carry_row;
  int            csa_cnt;
  int            csa_grp;
  int            csa_rem;

  always_comb begin
    csa_cur = '{default: '0};
    csa_nxt = '{default: '0};
    pp_row  = '0;
    csa_cnt = ROWS;
    csa_grp = 0;
    csa_rem = 0;

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if ((i == N-1) != (j == N-1))
          pp_row[j] = ~(a1[i] & b1[j]);
        else
          pp_row[j] = a1[i] & b1[j];
      end
      csa_cur[i] = PW'(pp_row) << i;
    end
    csa_cur[N] = PW'(1) << N;

    // Layered 3:2 compression; leftover rows pass through to the next layer.
    // Columns with a constant-zero input collapse to half adders.
    for (int l = 0; l < LEVELS; l++) begin
      csa_nxt = '{default: '0};
      csa_grp = csa_cnt / 3;
      csa_rem = csa_cnt - 3 * csa_grp;
      for (int g = 0; g < ROWS / 3; g++) begin
        if (g < csa_grp) begin
          csa_nxt[2*g]   = csa_cur[3*g] ^ csa_cur[3*g+1] ^ csa_cur[3*g+2];
          csa_nxt[2*g+1] = ((csa_cur[3*g]   & csa_cur[3*g+1]) |
                            (csa_cur[3*g]   & csa_cur[3*g+2]) |
                            (csa_cur[3*g+1] & csa_cur[3*g+2])) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < csa_rem)
          csa_nxt[2*csa_grp+r] = csa_cur[3*csa_grp+r];
      end
      csa_cur = csa_nxt;
      csa_cnt = 2 * csa_grp + csa_rem;
    end

    sum_row   = csa_cur[0];
    carry_row = csa_cur[1];
  end

  logic          v2;
  logic [PW-1:0] sum2;
  logic [PW-1:0] carry2;
`ifdef WALLACE_MUL_ACC_EN
  logic          sgn2;
  logic          clr2;
`endif

  // ---------------- S3: carry-propagate add ----------------
  logic [PW-1:0] p_nxt;
  assign p_nxt = sum2 + carry2;

`ifdef WALLACE_MUL_ACC_EN
  logic [ACC_W-1:0] p_ext;
  assign p_ext = sgn2 ? ACC_W'($signed(p_nxt)) : ACC_W'(p_nxt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      v2        <= 1'b0;
      sum2      <= '0;
      carry2    <= '0;
      out_valid <= 1'b0;
      p         <= '0;
`ifdef WALLACE_MUL_ACC_EN
      sgn1      <= 1'b0;
      clr1      <= 1'b0;
      sgn2      <= 1'b0;
      clr2      <= 1'b0;
      acc       <= '0;
`endif
    end else if (adv) begin
      v1        <= in_valid;
      a1        <= {a_signed & a[WIDTH-1], a};
      b1        <= {b_signed & b[WIDTH-1], b};
      v2        <= v1;
      sum2      <= sum_row;
      carry2    <= carry_row;
      out_valid <= v2;
`ifdef WALLACE_MUL_ACC_EN
      sgn1      <= a_signed | b_signed;
      clr1      <= acc_clr;
      sgn2      <= sgn1;
      clr2      <= clr1;
`endif
      // Bubbles leave p (and acc) untouched so the running sum only sees real beats.
      if (v2) begin
        p <= p_nxt;
`ifdef WALLACE_MUL_ACC_EN
        acc <= (clr2 ? '0 : acc) + p_ext;
`endif
      end
    end
  end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
module tb_wallace_mul_pipe;

  localparam int W  = 8;
  localparam int AW = 2*W + 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           a_signed = 1'b0;
  logic           b_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] p;
`ifdef WALLACE_MUL_ACC_EN
  logic           acc_clr = 1'b0;
  logic [AW-1:0]  acc;
`endif

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [AW-1:0]  acc;
  } exp_t;

  exp_t           q[$];
  int             nvec = 0;
  int             nfail = 0;
  int             cyc = 0;
  int             last_acc_cyc = 0;
  int             first_cyc = 0;
  logic [AW-1:0]  acc_m = '0;
  logic           stall_prev = 1'b0;
  logic [2*W-1:0] p_prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wallace_mul_pipe #(
    .WIDTH(W)
`ifdef WALLACE_MUL_ACC_EN
    , .ACC_W(AW)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .a_signed(a_signed),
    .b_signed(b_signed),
`ifdef WALLACE_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p(p)
`ifdef WALLACE_MUL_ACC_EN
    , .acc(acc)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: plain signed multiply of the extended operands.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic xs, input logic ys);
    logic signed [W:0]     ex;
    logic signed [2*W+1:0] pr;
    logic signed [W:0]     ey;
    ex = {xs & x[W-1], x};
    ey = {ys & y[W-1], y};
    pr = ex * ey;
    return pr[2*W-1:0];
  endfunction

  // Drive one beat, wait (bounded) for acceptance, then queue its expectation.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic xs,
                      input logic ys, input logic clr, input logic [2*W-1:0] ep,
                      input logic [AW-1:0] eacc);
    bit ok;
    a = x; b = y; a_signed = xs; b_signed = ys; in_valid = 1'b1;
`ifdef WALLACE_MUL_ACC_EN
    acc_clr = clr;
`endif
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      nvec++; nfail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    q.push_back('{p: ep, acc: eacc});
    acc_m = eacc;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [W-1:0] x, input logic [W-1:0] y, input logic xs,
                        input logic ys, input logic clr);
    logic [2*W-1:0] pm;
    logic [AW-1:0]  ext;
    pm  = ref_mul(x, y, xs, ys);
    ext = (xs | ys) ? {{(AW-2*W){pm[2*W-1]}}, pm} : {{(AW-2*W){1'b0}}, pm};
    send(x, y, xs, ys, clr, pm, (clr ? '0 : acc_m) + ext);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      nvec++; nfail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor plus stall-behaviour checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL spurious_out: out_valid=1 with p=%0h, expected no result", p);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("p", 32'(p), 32'(e.p));
`ifdef WALLACE_MUL_ACC_EN
          check("acc", 32'(acc), 32'(e.acc));
`endif
        end
      end
      if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
      if (stall_prev) begin
        check("p_hold", 32'(p), 32'(p_prev));
        check("valid_hold", 32'(out_valid), 32'd1);
      end
      stall_prev = out_valid && !out_ready;
      p_prev     = p;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Signed x unsigned with latency check: 3 cycles from accept to out_valid.
    send(8'h80, 8'hFF, 1'b1, 1'b0, 1'b1, 16'h8080, 24'hFF8080);
    @(negedge clk); check("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_c2", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_c3", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    send(8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 16'h4000, 24'hFFC080);
    send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 16'hFE01, 24'h00BE81);
    drain();

    // Back-to-back across all four flag combinations at full rate.
    for (int i = 0; i < 20; i++) begin
      send_m(W'($urandom), W'($urandom), i[0], i[1], (i % 7) == 0);
      if (i == 0) first_cyc = last_acc_cyc;
    end
    check("b2b_rate", 32'(last_acc_cyc - first_cyc), 32'd19);
    drain();

    // Backpressure: out_ready low for 5 cycles while beats keep arriving.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_m(W'(8'h11 * i + 3), W'(8'hF0 - 8'h13 * i), i[1], i[0], 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Accumulator sequence: 12, then 12 + (-10) = 2, then cleared to 100.
    send(8'd3,  8'd4,  1'b0, 1'b0, 1'b1, 16'd12,   24'd12);
    send(8'hFE, 8'd5,  1'b1, 1'b0, 1'b0, 16'hFFF6, 24'd2);
    send(8'd10, 8'd10, 1'b0, 1'b0, 1'b1, 16'd100,  24'd100);
    drain();

    // Reset with three beats in flight: all are voided.
    send_m(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    send_m(8'h9C, 8'h07, 1'b1, 1'b0, 1'b0);
    send_m(8'hC3, 8'hA5, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_p", 32'(p), 32'd0);
`ifdef WALLACE_MUL_ACC_EN
    check("midrst_acc", 32'(acc), 32'd0);
`endif
    q.delete();
    acc_m = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("in_ready_after_midrst", 32'(in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(8'h7F, 8'h81, 1'b0, 1'b1, 1'b1, 16'hC0FF, 24'hFFC0FF);
    drain();
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
